async_handshake_rx_ctrl: RTL and testbench

- Receive-side controller for a 4-phase req/ack handshake arriving from an unrelated clock domain.
- Synchronizes the incoming request through a flip-flop chain and captures the quasi-static data bus.
- Presents each captured word on a local valid/ready interface, then sequences the acknowledge back to the sender.
- Sits at the `clk` domain boundary. It gives multi-bit transfers, which a plain bit synchronizer cannot carry safely.

---
 rtl/async_handshake_rx_ctrl_pkg.sv | 13 +
 rtl/async_handshake_rx_ctrl_sync_bit_chain.sv | 20 ++
 rtl/async_handshake_rx_ctrl.sv | 96 +++++++++
 tb/tb_async_handshake_rx_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_handshake_rx_ctrl_pkg.sv
// Shared types for the 4-phase handshake receive controller.
package async_handshake_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } rx_state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/async_handshake_rx_ctrl_sync_bit_chain.sv
// Single-bit flop chain bringing an asynchronous level into the clk domain.
module sync_bit_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= '0;
    else     ff_q <= {ff_q[STAGES-2:0], d};
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/async_handshake_rx_ctrl.sv
// Receive side of a 4-phase req/ack crossing: synchronize req, capture the
// quasi-static data bus once, hand it out on valid/ready, then sequence ack.
module async_handshake_rx_ctrl
  import async_handshake_rx_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  xfer_count
);

  // Out-of-range depths are pulled back into the supported window.
  localparam int STAGES_EFF = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES :
                              (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES :
                              SYNC_STAGES;

  logic req_s;

  sync_bit_chain #(.STAGES(STAGES_EFF)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_async),
    .q   (req_s)
  );

  rx_state_e         state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // data_async is guaranteed stable once req_s is seen high.
      ST_IDLE: begin
        if (req_s) begin
          data_d  = data_async;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ACK;
        end
      end
      // A req that already dropped during VALID releases ack on the next edge.
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack_out    = ack_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_async_handshake_rx_ctrl.sv
// Directed bench for async_handshake_rx_ctrl with a cycle-level reference model.
module tb_async_handshake_rx_ctrl;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int CNT_W  = 4;
  localparam int WAIT_MAX = 50;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_async;
  logic [DATA_W-1:0] data_async;
  logic              ack_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  xfer_count;

  int n_assert = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  async_handshake_rx_ctrl #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_async  (req_async),
    .data_async (data_async),
    .ack_out    (ack_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: req_s is the req level seen SYNC edges ago; a word is
  // held from capture until accepted, ack rises on acceptance and falls once
  // the delayed req is low.
  logic              req_hist [SYNC];
  bit                m_valid, m_ack;
  logic [DATA_W-1:0] m_data;
  int                m_accepts;
  logic [DATA_W-1:0] exp_q [$];

  always @(posedge clk) begin
    logic rs;
    rs = req_hist[SYNC-1];
    if (rst) begin
      for (int i = 0; i < SYNC; i++) req_hist[i] = 1'b0;
      m_valid = 0; m_ack = 0; m_data = '0; m_accepts = 0;
    end else begin
      for (int i = SYNC-1; i > 0; i--) req_hist[i] = req_hist[i-1];
      req_hist[0] = req_async;
      if (m_ack) begin
        if (!rs) m_ack = 0;
      end else if (m_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) chk("sb_unexpected_word", {24'h0, m_data}, 32'hDEAD);
          else chk("sb_order", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
          m_valid = 0; m_ack = 1; m_accepts++;
        end
      end else if (rs) begin
        m_valid = 1; m_data = data_async;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid", out_valid, m_valid);
      chk("cyc_ack",   ack_out,   m_ack);
      chk("cyc_data",  out_data,  m_data);
      chk("cyc_count", xfer_count, m_accepts % (1 << CNT_W));
      chk("ack_while_valid", ack_out & out_valid, 1'b0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack_out !== v && n < WAIT_MAX) begin tick(); n++; end
    chk("wait_ack", ack_out, v);
  endtask

  task automatic wait_valid(input logic v);
    int n = 0;
    while (out_valid !== v && n < WAIT_MAX) begin tick(); n++; end
    chk("wait_valid", out_valid, v);
  endtask

  // Full 4-phase transfer; the next call re-raises req right after ack falls.
  task automatic send(input logic [DATA_W-1:0] d);
    exp_q.push_back(d);
    data_async = d;
    req_async  = 1'b1;
    wait_ack(1'b1);
    req_async  = 1'b0;
    wait_ack(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_async = 1'b0; data_async = '0; out_ready = 1'b1;
    tick();
    started = 1'b1;
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ack",   ack_out,   1'b0);
    chk("rst_data",  out_data,  8'h00);
    chk("rst_count", xfer_count, 4'h0);
    rst = 1'b0;
    tick();

    // 1: single transfer latency
    exp_q.push_back(8'hA5);
    data_async = 8'hA5; req_async = 1'b1;
    tick(); chk("t1_e1_valid", out_valid, 1'b0);
    tick(); chk("t1_e2_valid", out_valid, 1'b0);
    tick(); chk("t1_e3_valid", out_valid, 1'b1);
            chk("t1_e3_data",  out_data, 8'hA5);
            chk("t1_e3_ack",   ack_out, 1'b0);
    tick(); chk("t1_e4_ack",   ack_out, 1'b1);
            chk("t1_e4_count", xfer_count, 4'd1);
    tick();
    req_async = 1'b0;
    tick(); chk("t1_e6_ack", ack_out, 1'b1);
    tick(); chk("t1_e7_ack", ack_out, 1'b1);
    tick(); chk("t1_e8_ack", ack_out, 1'b0);

    // 2: backpressure
    out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    data_async = 8'h3C; req_async = 1'b1;
    wait_valid(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", out_valid, 1'b1);
      chk("t2_hold_data",  out_data, 8'h3C);
      chk("t2_hold_ack",   ack_out, 1'b0);
      tick();
    end
    chk("t2_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("t2_ack",   ack_out, 1'b1);
    chk("t2_valid", out_valid, 1'b0);
    chk("t2_count", xfer_count, 4'd2);
    req_async = 1'b0;
    wait_ack(1'b0);

    // 3: back-to-back stream
    for (int i = 1; i <= 5; i++) send(DATA_W'(i));
    repeat (4) tick();
    chk("t3_count", xfer_count, 4'd7);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_idle_valid", out_valid, 1'b0);

    // 4: reset while VALID with req held
    out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    data_async = 8'h5A; req_async = 1'b1;
    wait_valid(1'b1);
    rst = 1'b1;
    tick();
    chk("t4_rst_valid", out_valid, 1'b0);
    chk("t4_rst_ack",   ack_out, 1'b0);
    chk("t4_rst_count", xfer_count, 4'd0);
    rst = 1'b0;
    tick(); chk("t4_r1_valid", out_valid, 1'b0);
    tick(); chk("t4_r2_valid", out_valid, 1'b0);
    tick(); chk("t4_r3_valid", out_valid, 1'b1);
            chk("t4_r3_data",  out_data, 8'h5A);
    out_ready = 1'b1;
    tick(); chk("t4_ack", ack_out, 1'b1);
            chk("t4_count", xfer_count, 4'd1);
    req_async = 1'b0;
    wait_ack(1'b0);

    // 6: req drops while VALID
    out_ready = 1'b0;
    exp_q.push_back(8'h77);
    data_async = 8'h77; req_async = 1'b1;
    wait_valid(1'b1);
    req_async = 1'b0;
    repeat (3) tick();
    chk("t6_held_valid", out_valid, 1'b1);
    chk("t6_held_data",  out_data, 8'h77);
    out_ready = 1'b1;
    tick(); chk("t6_ack_hi", ack_out, 1'b1);
            chk("t6_count",  xfer_count, 4'd2);
    tick(); chk("t6_ack_lo", ack_out, 1'b0);
    repeat (3) tick();
    chk("t6_no_redeliver", out_valid, 1'b0);
    chk("t6_ack_idle", ack_out, 1'b0);

    // 5: counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send(DATA_W'(8'h80 + i));
      if (i == 15) chk("t5_cnt15", xfer_count, 4'hF);
      if (i == 16) chk("t5_cnt16", xfer_count, 4'h0);
      if (i == 17) chk("t5_cnt17", xfer_count, 4'h1);
    end
    repeat (3) tick();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
